// File: rtl/data_mem_arbiter_if.sv
// Bundle of the two requester ports and the data-memory port shared by data_mem_arbiter.
interface data_mem_arbiter_if;
    logic        req0;
    logic        we0;
    logic [31:0] addr0;
    logic [31:0] wd0;
    logic        ack0;
    logic [31:0] rdata0;
    logic        err0;

    logic        req1;
    logic        we1;
    logic [31:0] addr1;
    logic [31:0] wd1;
    logic        ack1;
    logic [31:0] rdata1;
    logic        err1;

    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    // arbiter side
    modport slave (
        input  req0, we0, addr0, wd0,
        input  req1, we1, addr1, wd1,
        input  mem_rd,
        output ack0, rdata0, err0,
        output ack1, rdata1, err1,
        output mem_addr, mem_we, mem_wd
    );

    // requester side
    modport master (
        output req0, we0, addr0, wd0,
        output req1, we1, addr1, wd1,
        input  ack0, rdata0, err0,
        input  ack1, rdata1, err1
    );

    // data memory side
    modport mem (
        input  mem_addr, mem_we, mem_wd,
        output mem_rd
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin two-port arbiter in front of the single-port data memory.
// Optional address range checking is enabled by defining ADDR_RANGE_CHECK_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no transaction in flight, waiting for any REQ
// S_ACCESS | memory bus driven for granted port, read data captured
// S_RESP   | ACK pulsed for granted port, other port may be granted
module data_mem_arbiter #(
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input logic              clk,
    input logic              rst_n,
    data_mem_arbiter_if.slave bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        pri_q, pri_d;
    logic        gsel_q, gsel_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        err0_q, err0_d;
    logic        err1_q, err1_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wd_q, mem_wd_d;

    logic        grant_vld;
    logic        grant_port;
    logic        oor0, oor1;
    logic        g_we, g_oor;
    logic [31:0] g_addr, g_wd, g_maddr;
    logic        c_oor;

    // DEPTH documents the memory size; decoding is driven by AW alone.
    logic unused_cfg;
    assign unused_cfg = ^(32'(DEPTH) ^ 32'(AW));

`ifdef ADDR_RANGE_CHECK_EN
    assign oor0    = (bus.addr0 >> AW) != 32'd0;
    assign oor1    = (bus.addr1 >> AW) != 32'd0;
    assign g_maddr = {{(32-AW){1'b0}}, g_addr[AW-1:0]};
`else
    assign oor0    = 1'b0;
    assign oor1    = 1'b0;
    assign g_maddr = g_addr;
`endif

    // In RESP the port just acknowledged is excluded: its REQ is still the old one.
    always_comb begin
        grant_vld  = 1'b0;
        grant_port = 1'b0;
        case (state_q)
            S_IDLE: begin
                grant_vld  = bus.req0 | bus.req1;
                grant_port = (bus.req0 & bus.req1) ? pri_q : bus.req1;
            end
            S_RESP: begin
                grant_port = ~gsel_q;
                grant_vld  = gsel_q ? bus.req0 : bus.req1;
            end
            default: begin
                grant_vld  = 1'b0;
                grant_port = 1'b0;
            end
        endcase
    end

    assign g_we   = grant_port ? bus.we1   : bus.we0;
    assign g_addr = grant_port ? bus.addr1 : bus.addr0;
    assign g_wd   = grant_port ? bus.wd1   : bus.wd0;
    assign g_oor  = grant_port ? oor1      : oor0;
    assign c_oor  = gsel_q     ? oor1      : oor0;

    always_comb begin
        state_d    = state_q;
        pri_d      = pri_q;
        gsel_d     = gsel_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        err0_d     = err0_q;
        err1_d     = err1_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_wd_d   = mem_wd_q;

        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    state_d    = S_ACCESS;
                    gsel_d     = grant_port;
                    mem_we_d   = g_we & ~g_oor;
                    mem_addr_d = g_maddr;
                    mem_wd_d   = g_wd;
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
                // MEM_RD still reflects the pre-write word at this edge
                if (gsel_q) begin
                    ack1_d   = 1'b1;
                    err1_d   = c_oor;
                    rdata1_d = c_oor ? 32'd0 : bus.mem_rd;
                end else begin
                    ack0_d   = 1'b1;
                    err0_d   = c_oor;
                    rdata0_d = c_oor ? 32'd0 : bus.mem_rd;
                end
            end
            S_RESP: begin
                pri_d = ~gsel_q;
                if (grant_vld) begin
                    state_d    = S_ACCESS;
                    gsel_d     = grant_port;
                    mem_we_d   = g_we & ~g_oor;
                    mem_addr_d = g_maddr;
                    mem_wd_d   = g_wd;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pri_q      <= 1'b0;
            gsel_q     <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
            rdata0_q   <= 32'd0;
            rdata1_q   <= 32'd0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= 32'd0;
            mem_wd_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            pri_q      <= pri_d;
            gsel_q     <= gsel_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            err0_q     <= err0_d;
            err1_q     <= err1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_wd_q   <= mem_wd_d;
        end
    end

    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.err0     = err0_q;
    assign bus.err1     = err1_q;
    assign bus.rdata0   = rdata0_q;
    assign bus.rdata1   = rdata1_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_wd   = mem_wd_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: a 128-word memory model with combinational read,
// and a scoreboard of expected ACK port / RDATA / ERR values popped on every ACK.
module tb_data_mem_arbiter;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

`ifdef ADDR_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mem_model [128];
    logic [31:0] ref_mem   [128];

    data_mem_arbiter_if bus ();

    data_mem_arbiter #(.DEPTH(128), .AW(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.mem_rd = mem_model[bus.mem_addr[6:0]];

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem_model[i] = 32'(i);
            ref_mem[i]   = 32'(i);
        end
        forever begin
            @(posedge clk);
            if (bus.mem_we) mem_model[bus.mem_addr[6:0]] <= bus.mem_wd;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_oor(input logic [31:0] a);
        return RANGE_EN && (a[31:7] != 25'd0);
    endfunction

    function automatic logic [31:0] exp_maddr(input logic [31:0] a);
        return RANGE_EN ? {25'd0, a[6:0]} : a;
    endfunction

    // Scoreboard consumer: every ACK must match the oldest outstanding expectation.
    always @(negedge clk) begin : sb_mon
        exp_t e;
        if (rst_n && (bus.ack0 || bus.ack1)) begin
            check("ack_onehot", 64'(bus.ack0 & bus.ack1), 64'd0);
            check("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("sb_port", 64'(bus.ack1), 64'(e.port));
                check("sb_rdata", 64'(bus.ack1 ? bus.rdata1 : bus.rdata0), 64'(e.rdata));
                check("sb_err", 64'(bus.ack1 ? bus.err1 : bus.err0), 64'(e.err));
            end
        end
    end

    task automatic drive(input logic p, input logic r, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        if (p) begin
            bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wd1 = d;
        end else begin
            bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wd0 = d;
        end
    endtask

    task automatic push_exp(input logic p, input logic we, input logic [31:0] a,
                            input logic [31:0] d);
        exp_t e;
        e.port  = p;
        e.err   = exp_oor(a);
        e.rdata = e.err ? 32'd0 : ref_mem[a[6:0]];
        sb_q.push_back(e);
        if (we && !e.err) ref_mem[a[6:0]] = d;
    endtask

    task automatic wait_ack(input logic p, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(p ? bus.ack1 : bus.ack0) && n < 20);
        check("ack_seen", 64'(p ? bus.ack1 : bus.ack0), 64'd1);
    endtask

    task automatic check_zero_outputs(input string pfx);
        check({pfx, "_ctrl"}, 64'({bus.ack0, bus.ack1, bus.err0, bus.err1, bus.mem_we}), 64'd0);
        check({pfx, "_rdata"}, {bus.rdata0, bus.rdata1}, 64'd0);
        check({pfx, "_membus"}, {bus.mem_addr, bus.mem_wd}, 64'd0);
    endtask

    // One isolated transaction from an idle arbiter, with bus and latency checks.
    task automatic single(input logic p, input logic we, input logic [31:0] a,
                          input logic [31:0] d);
        int n;
        push_exp(p, we, a, d);
        @(negedge clk);
        drive(p, 1'b1, we, a, d);
        @(negedge clk);
        check("access_mem_we", 64'(bus.mem_we), 64'(we && !exp_oor(a)));
        check("access_mem_addr", 64'(bus.mem_addr), 64'(exp_maddr(a)));
        check("access_mem_wd", 64'(bus.mem_wd), 64'(d));
        wait_ack(p, n);
        check("ack_latency", 64'(n), 64'd1);
        check("resp_mem_we", 64'(bus.mem_we), 64'd0);
        @(negedge clk);
        drive(p, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin : stim
        int          n, c0, c1, done, idx0, idx1, last_c, bad_idle;
        logic        drop0, drop1;

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // port 0 write of address 5 returns old contents, then read back
        single(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF);
        single(1'b0, 1'b0, 32'd5, 32'd0);

        // reset during ACCESS of a write to address 9
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'd9, 32'h1234_5678);
        @(negedge clk);
        check("rstmid_access_we", 64'(bus.mem_we), 64'd1);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("rstmid");
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rstmid_word9", 64'(mem_model[9]), 64'(ref_mem[9]));

        // simultaneous reads after reset: port 0 first, port 1 two cycles later
        push_exp(1'b0, 1'b0, 32'd3, 32'd0);
        push_exp(1'b1, 1'b0, 32'd7, 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'd3, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 32'd7, 32'd0);
        wait_ack(1'b0, n);
        check("contend_ack0_latency", 64'(n), 64'd2);
        c0 = cyc;
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        wait_ack(1'b1, n);
        c1 = cyc;
        check("contend_ack1_gap", 64'(c1 - c0), 64'd2);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

        // continuous contention: port 0 writes 40+i, port 1 reads 40+i right after
        for (int i = 0; i < 4; i++) begin
            push_exp(1'b0, 1'b1, 32'(40 + i), 32'hA000_0000 + 32'(i));
            push_exp(1'b1, 1'b0, 32'(40 + i), 32'd0);
        end
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'd40, 32'hA000_0000);
        drive(1'b1, 1'b1, 1'b0, 32'd40, 32'd0);
        done = 0; idx0 = 1; idx1 = 1; last_c = 0; drop0 = 1'b0; drop1 = 1'b0;
        for (int t = 0; t < 40 && done < 8; t++) begin
            @(negedge clk);
            if (drop0) begin drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0); drop0 = 1'b0; end
            if (drop1) begin drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0); drop1 = 1'b0; end
            if (bus.ack0 || bus.ack1) begin
                if (done > 0) check("stream_ack_gap", 64'(cyc - last_c), 64'd2);
                last_c = cyc;
                done++;
            end
            if (bus.ack0) begin
                if (idx0 < 4) begin
                    drive(1'b0, 1'b1, 1'b1, 32'(40 + idx0), 32'hA000_0000 + 32'(idx0));
                    idx0++;
                end else drop0 = 1'b1;
            end
            if (bus.ack1) begin
                if (idx1 < 4) begin
                    drive(1'b1, 1'b1, 1'b0, 32'(40 + idx1), 32'd0);
                    idx1++;
                end else drop1 = 1'b1;
            end
        end
        check("stream_done", 64'(done), 64'd8);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

        // idle bus for 20 cycles
        bad_idle = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.mem_we || bus.ack0 || bus.ack1) bad_idle++;
        end
        check("idle_quiet", 64'(bad_idle), 64'd0);

        // address 9 survived the abandoned write
        single(1'b1, 1'b0, 32'd9, 32'd0);

`ifdef ADDR_RANGE_CHECK_EN
        single(1'b1, 1'b1, 32'h0000_0080, 32'hCAFE_F00D);
        check("oor_write_word0", 64'(mem_model[0]), 64'(ref_mem[0]));
        single(1'b0, 1'b0, 32'hFFFF_0004, 32'd0);
`else
        single(1'b1, 1'b0, 32'h0000_0083, 32'd0);
        single(1'b1, 1'b1, 32'h0000_010C, 32'h0000_0055);
        single(1'b0, 1'b0, 32'd12, 32'd0);
`endif

        repeat (2) @(negedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter that shares the single-port data memory between a primary requester (processor load/store stage, port 0) and a secondary requester (debug/DMA loader, port 1). Accepts one request per port under a REQ/ACK handshake, grants the memory to one port at a time with round-robin priority, and drives the memory's address, write-enable and write-data inputs for exactly one cycle per transaction. The memory's combinational read data is captured into a register and returned with ACK. Sits between the requesters and the data memory, which is unchanged.

## Interface
- DEPTH, 128: memory depth in 32-bit words; word-indexed addressing.
- AW, 7: word address bits actually decoded; DEPTH must equal 2**AW.
- CLK input 1: single clock; all state updates on rising edge.
- RESET_N input 1: asynchronous, active-low reset.
- REQ0 / REQ1 input 1: request valid, port 0 / port 1.
- WE0 / WE1 input 1: 1 = write, 0 = read.
- ADDR0 / ADDR1 input 32: word address.
- WD0 / WD1 input 32: write data.
- ACK0 / ACK1 output 1: one-cycle completion pulse.
- RDATA0 / RDATA1 output 32: read data, valid while ACKn = 1.
- ERR0 / ERR1 output 1: out-of-range flag, valid while ACKn = 1 (see Configuration).
- MEM_ADDR output 32: address to the memory.
- MEM_WE output 1: write enable to the memory.
- MEM_WD output 32: write data to the memory.
- MEM_RD input 32: combinational read data from the memory.

## Operation
- Requester rule: once REQn rises, WEn, ADDRn and WDn are held stable until the cycle ACKn = 1. REQn drops in the cycle after ACKn, or stays high to issue a new transaction.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any REQ is high, grant one port, latch the port id in GSEL and go to ACCESS. Otherwise stay in IDLE.
- ACCESS: drive MEM_ADDR, MEM_WD and MEM_WE from the granted port.
  - MEM_WE = WEn and not ERR.
  - Capture MEM_RD into the RDATA register for that port, capture the range result, then go to RESP.
- RESP: pulse ACKn for the granted port and flip the priority pointer to the other port.
  - If the other port's REQ is high, grant it and go straight to ACCESS.
  - Otherwise go to IDLE.
  - The port just acknowledged is never re-granted in its own RESP cycle. Its REQ is still high from the finished transaction.
- Arbitration: round-robin with pointer PRI (reset 0 = port 0 favoured).
  - Only one port requesting: that port wins.
  - Both requesting: the port named by PRI wins.
  - PRI flips after each completed transaction.
- Outside ACCESS: MEM_WE = 0 and MEM_ADDR / MEM_WD are held at their last values, so no spurious writes occur.
- Write transactions: RDATAn returns the pre-write contents of the addressed word, because MEM_RD is sampled before the write edge.
- Reset values: state IDLE, PRI = 0, GSEL = 0, ACK0 = ACK1 = 0, ERR0 = ERR1 = 0, RDATA0 = RDATA1 = 0, MEM_WE = 0, MEM_ADDR = 0, MEM_WD = 0.
- Reset mid-transaction: the transaction is abandoned and no ACK is issued. If RESET_N asserts before the ACCESS-cycle clock edge, the write does not occur.

## Timing
- Latency from the REQ-sample edge to the ACK cycle:
  - From IDLE: REQ sampled at edge k, ACCESS in cycle k+1, ACK in cycle k+2.
  - A port waiting behind the other is granted in the other's RESP cycle: ACCESS in the next cycle, ACK one cycle after that.
- Throughput: one transaction every 2 cycles under contention.
- ACK outputs, RDATA outputs, ERR outputs and MEM_WE are registered. MEM_ADDR and MEM_WD are registered.
- MEM_RD is sampled at the end of the ACCESS cycle.

## Configuration
- ADDR_RANGE_CHECK_EN defined:
  - Any address with ADDRn[31:AW] != 0 sets ERRn with ACKn.
  - An out-of-range write is suppressed (MEM_WE = 0).
  - An out-of-range read returns RDATAn = 0.
  - MEM_ADDR is driven as {{(32-AW){1'b0}}, ADDRn[AW-1:0]}.
- ADDR_RANGE_CHECK_EN undefined:
  - ERR0 and ERR1 are tied to 0.
  - The full 32-bit ADDRn passes to MEM_ADDR and writes are never suppressed.

## Test plan
- Port 0 write: ADDR0 = 5, WD0 = 0xDEADBEEF, REQ0 at edge 1 -> MEM_WE = 1 in cycle 2 only. ACK0 in cycle 3 with RDATA0 = 0x00000005 (old data). A following read of address 5 returns 0xDEADBEEF.
- Simultaneous REQ0 and REQ1 reads, addresses 3 and 7, after reset -> port 0 is served first (ACK0, RDATA0 = 3). ACK1 follows 2 cycles later with RDATA1 = 7.
- Both ports requesting continuously, 8 transactions -> ACK alternates 0,1,0,1,… and no port is granted twice in a row.
- RESET_N pulsed low during ACCESS of a write to address 9 -> no ACK, all outputs return to 0. Address 9 is unchanged, provided reset is asserted before the ACCESS-cycle clock edge.
- ADDR_RANGE_CHECK_EN defined, write ADDR1 = 0x80 -> ACK1 with ERR1 = 1, MEM_WE stays 0, and no memory word changes.
- Idle bus, no REQ for 20 cycles -> MEM_WE = 0 and ACK0 = ACK1 = 0 throughout.
